// File: rtl/sram_sched_pkg.sv
// Shared definitions for the SRAM scheduler: FSM states, requester ids and
// the latched-request record.
package sram_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_e;

  localparam logic       REQ_IFU = 1'b0;
  localparam logic       REQ_LSU = 1'b1;
  localparam logic [3:0] BE_IDLE = 4'hF;

  // Everything about the granted access except its address.
  typedef struct packed {
    logic        who;
    logic        we_n;
    logic [3:0]  be_n;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_sched_wait_cnt.sv
// Wait-state counter: cleared on load, counts up each cycle and flags when
// WAIT_CYC extra cycles have elapsed.
module sram_sched_wait_cnt #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(WAIT_CYC + 1) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CW'(WAIT_CYC));

  // Load wins; otherwise count up and park on the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)       cnt_d = '0;
    else if (!done_o) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_sched.sv
// Registered scheduler for one async SRAM shared by the IFU and LSU ports.
// RAM pins are registered from the next state so they change cleanly on
// the clock edge that enters each phase.
module sram_sched
  import sram_sched_pkg::*;
#(
  parameter int unsigned WAIT_CYC   = 1,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_i,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic [31:0]       ifu_rdata_o,
  output logic              ifu_resp_o,
  input  logic              lsu_req_i,
  input  logic              lsu_we_n_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [3:0]        lsu_be_n_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_resp_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_be_n_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1) + 1;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic              ifu_win, cnt_load, cnt_done;

  logic              ce_n_q, oe_n_q, we_n_q, ce_n_d, oe_n_d, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ifu_resp_q, ifu_resp_d, lsu_resp_q, lsu_resp_d;

  // Counter restarts whenever a timed phase (RD / WR_PULSE) is entered.
  assign cnt_load = (state_d != state_q) && (state_d == RD || state_d == WR_PULSE);

  sram_sched_wait_cnt #(.WAIT_CYC(WAIT_CYC)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .done_o (cnt_done)
  );

  // Arbitration, request latch, starvation tracking and phase sequencing.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    starve_d    = starve_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    // LSU normally wins ties; the IFU gets through once LSU has hogged enough.
    ifu_win     = ifu_req_i && (!lsu_req_i || starve_q == SW'(STARVE_MAX));
    unique case (state_q)
      IDLE: begin
        if (ifu_req_i || lsu_req_i) begin
          addr_d     = ifu_win ? ifu_addr_i : lsu_addr_i;
          req_d.who  = ifu_win ? REQ_IFU : REQ_LSU;
          req_d.we_n = ifu_win ? 1'b1 : lsu_we_n_i;
          req_d.be_n = lsu_be_n_i;
          req_d.wdata = lsu_wdata_i;
          if (ifu_win || !ifu_req_i)               starve_d = '0;
          else if (starve_q != SW'(STARVE_MAX))    starve_d = starve_q + SW'(1);
          state_d = (ifu_win || lsu_we_n_i) ? RD : WR_SETUP;
        end
      end
      RD: begin
        if (cnt_done) begin
          state_d = DONE;
          if (req_q.who == REQ_IFU) ifu_rdata_d = ram_rdata_i;
          else                      lsu_rdata_d = ram_rdata_i;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_done) state_d = WR_HOLD;
      WR_HOLD:  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pin values for the phase being entered; registered below.
  always_comb begin
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    be_n_d     = BE_IDLE;
    wdata_d    = '0;
    ifu_resp_d = 1'b0;
    lsu_resp_d = 1'b0;
    unique case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        ce_n_d  = 1'b0;
        we_n_d  = (state_d != WR_PULSE);
        be_n_d  = req_d.be_n;
        wdata_d = req_d.wdata;
      end
      DONE: begin
        ifu_resp_d = (req_d.who == REQ_IFU);
        lsu_resp_d = (req_d.who == REQ_LSU);
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '{who: REQ_IFU, we_n: 1'b1, be_n: BE_IDLE, wdata: '0};
      addr_q      <= '0;
      starve_q    <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= BE_IDLE;
      wdata_q     <= '0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      starve_q    <= starve_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      wdata_q     <= wdata_d;
      ifu_resp_q  <= ifu_resp_d;
      lsu_resp_q  <= lsu_resp_d;
    end
  end

  assign ifu_rdata_o = ifu_rdata_q;
  assign lsu_rdata_o = lsu_rdata_q;
  assign ifu_resp_o  = ifu_resp_q;
  assign lsu_resp_o  = lsu_resp_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_be_n_o  = be_n_q;
  assign ram_ce_n_o  = ce_n_q;
  assign ram_oe_n_o  = oe_n_q;
  assign ram_we_n_o  = we_n_q;

endmodule

// File: doc/sram_sched.md
Name: sram_sched

Overview:
- Sequential scheduler for one asynchronous SRAM chip (BaseRAM or ExtRAM), shared between the IFU fetch port and the LSU data port.
- Replaces same-cycle combinational grant with a registered FSM: arbitration, programmable wait states, write setup/pulse/hold shaping and a one-cycle response pulse.
- Instantiated once per SRAM between the core-side memory ports and the board SRAM pins; UART decode stays outside this block.

Parameters:
- WAIT_CYC, 1, extra access cycles beyond the first for a read, and pulse width beyond the first for a write (0 legal).
- ADDR_W, 20, SRAM word-address width.
- STARVE_MAX, 2, consecutive LSU grants allowed while the IFU is pending.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_req_i  in  1  fetch request, level, held until ifu_resp_o.
- ifu_addr_i  in  ADDR_W  fetch word address, stable while req is high.
- ifu_rdata_o  out  32  registered fetch data.
- ifu_resp_o  out  1  one-cycle completion pulse.
- lsu_req_i  in  1  data request, level, held until lsu_resp_o.
- lsu_we_n_i  in  1  0 = write, 1 = read.
- lsu_addr_i  in  ADDR_W  data word address.
- lsu_be_n_i  in  4  write byte enables, active low.
- lsu_wdata_i  in  32  write data.
- lsu_rdata_o  out  32  registered load data.
- lsu_resp_o  out  1  one-cycle completion pulse.
- ram_wdata_o  out  32  SRAM write data.
- ram_rdata_i  in  32  SRAM read data.
- ram_addr_o  out  ADDR_W  SRAM address.
- ram_be_n_o  out  4  SRAM byte enables.
- ram_ce_n_o / ram_oe_n_o / ram_we_n_o  out  1 each  SRAM chip enable / output enable / write enable.

Behaviour:
- All RAM-side outputs are registered.
- Reset values:
  - state IDLE
  - ram_ce_n_o, ram_oe_n_o, ram_we_n_o = 1; ram_be_n_o = 4'hF
  - ram_addr_o = 0; ram_wdata_o = 0
  - both resp = 0; both rdata = 0; wait counter = 0; starve counter = 0
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - Samples requests.
  - LSU wins ties unless starve counter == STARVE_MAX and ifu_req_i = 1; then the IFU wins.
  - Latches requester id, address, be_n and wdata.
  - Goes to RD (IFU, or LSU with we_n = 1) or WR_SETUP (LSU with we_n = 0).
  - With no request it stays idle with all controls deasserted.
- RD: ce_n = 0, oe_n = 0, we_n = 1, be_n = 0000 for WAIT_CYC+1 cycles. ram_rdata_i is captured into the winner's rdata register on the last RD cycle.
- WR_SETUP, 1 cycle: ce_n = 0, oe_n = 1, we_n = 1; addr, wdata and be_n driven.
- WR_PULSE, WAIT_CYC+1 cycles: we_n = 0; addr, data and be_n held.
- WR_HOLD, 1 cycle: we_n = 1, ce_n still 0, data held.
- DONE, 1 cycle:
  - Winner's resp = 1; RAM controls deasserted.
  - Next state is always IDLE.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency (cycle 0 = IDLE sample):
  - read: resp in cycle WAIT_CYC+2
  - write: resp in cycle WAIT_CYC+4
- Loser handling: the losing requester sees resp = 0 and stays pending. It has no timeout.
- Starve counter:
  - Increments on each LSU grant made while ifu_req_i = 1.
  - Clears on any IFU grant, and on any LSU grant made while ifu_req_i = 0.
  - Saturates at STARVE_MAX.
- Wait counter: width $clog2(WAIT_CYC+1)+1. Loaded with 0 on entry to RD or WR_PULSE; exits when it equals WAIT_CYC.
- rdata registers hold their value until the next read by the same requester. Writes never alter lsu_rdata_o.
- Reset in any state returns all of the reset values above on the next edge. A write interrupted in WR_PULSE leaves SRAM contents undefined, and that is accepted.
- ram_wdata_o = 0 outside the write states.
- lsu_be_n_i is ignored for reads.
- Only one outstanding access exists at a time, so ifu_resp_o and lsu_resp_o are never high in the same cycle.

Decomposition:
- Shared header mem_defs.vh holds:
  - state encodings (3-bit localparams)
  - requester id constants REQ_IFU = 0, REQ_LSU = 1
  - BE_IDLE = 4'hF
- One optional sub-module, sram_wait_cnt: a loadable up-counter with a done flag. Otherwise the block is a single module.

Test Plan (WAIT_CYC = 1, STARVE_MAX = 2):
- IFU read, addr 0x00010, model returns 0x12345678:
  - RD in cycles 1–2; ifu_resp_o = 1 in cycle 3 only.
  - ifu_rdata_o = 0x12345678; lsu_resp_o stays 0.
- LSU write, addr 0x00020, be_n 4'b1100, wdata 0xAABBCCDD:
  - we_n low in cycles 2–3 only; ce_n low in cycles 1–4; lsu_resp_o in cycle 5.
  - Model bytes [1:0] = 0xCCDD; upper bytes unchanged.
- Both requesting in the same cycle, LSU read then LSU held high: grant order LSU, LSU, IFU. IFU resp arrives after two LSU resps; starve counter then reads 0.
- WAIT_CYC = 0 instance: read resp in cycle 2; write we_n low for exactly 1 cycle, resp in cycle 4.
- rst asserted in WR_PULSE: the next edge gives we_n = 1, ce_n = 1, be_n = 4'hF, state IDLE, no resp pulse.
- Idle for 10 cycles with no request: ce_n, oe_n, we_n stay 1, addr stays 0, no resp.
